// File: rtl/elastic_buf_pkg.sv
// Shared definitions for the RX elastic buffer: SKP code groups, read-side FSM
// states and Gray/binary helpers.
package elastic_buf_pkg;

  localparam logic [9:0] SKP_SYM_N = 10'h0F4;
  localparam logic [9:0] SKP_SYM_P = 10'h30B;

  typedef enum logic {FILL, RUN} state_t;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int unsigned i = 31; i > 0; i--) b[i-1] = b[i] ^ g[i-1];
    return b;
  endfunction

endpackage

// File: rtl/read_pointer_control_if.sv
// Read-port bundle of the elastic buffer: write-pointer/RAM inputs and the
// read-side symbol, pointer and status outputs.
interface read_pointer_control_if #(
  parameter int unsigned DATA_WIDTH   = 10,
  parameter int unsigned BUFFER_DEPTH = 16
);
  import elastic_buf_pkg::*;

  localparam int unsigned ADDR_W = addr_w(BUFFER_DEPTH);

  logic [ADDR_W:0]       gray_write_pointer;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_W-1:0]     read_address;
  logic [ADDR_W:0]       gray_read_pointer;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  underflow;
  logic                  skp_added;
  logic                  skp_removed;

  modport master (
    input  gray_write_pointer, data_in,
    output read_address, gray_read_pointer, data_out, data_valid,
           underflow, skp_added, skp_removed
  );

  modport slave (
    output gray_write_pointer, data_in,
    input  read_address, gray_read_pointer, data_out, data_valid,
           underflow, skp_added, skp_removed
  );

endinterface

// File: rtl/binToGray.sv
// Binary-to-Gray converter.
module binToGray #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  import elastic_buf_pkg::*;

  assign gray = WIDTH'(bin2gray(32'(bin)));

endmodule

// File: rtl/grayToBin.sv
// Gray-to-binary converter, counterpart of binToGray.
module grayToBin #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  import elastic_buf_pkg::*;

  assign bin = WIDTH'(gray2bin(32'(gray)));

endmodule

// File: rtl/read_pointer_control.sv
// RX elastic buffer read side: write-pointer sync, fill level, symbol read,
// SKP insert/delete and underflow. `RPC_SYNC3_EN selects a 3-flop synchroniser.
module read_pointer_control
  import elastic_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 10,
  parameter int unsigned BUFFER_DEPTH = 16
) (
  input logic                    read_clk,
  input logic                    rst,
  input logic                    buffer_mode,
  read_pointer_control_if.master bus
);

  localparam int unsigned ADDR_W = addr_w(BUFFER_DEPTH);
  localparam int unsigned PW     = ADDR_W + 1;
`ifdef RPC_SYNC3_EN
  localparam int unsigned SYNC_N = 3;
`else
  localparam int unsigned SYNC_N = 2;
`endif
  localparam logic [PW-1:0] T_EMPTY = PW'(2);
  localparam logic [PW-1:0] T_HALF  = PW'(BUFFER_DEPTH / 2);

  state_t                state, state_next;
  logic [PW-1:0]         wsync [SYNC_N];
  logic [PW-1:0]         wbin, rbin, rbin_next, rgray, rgray_next;
  logic [PW-1:0]         fill, target, lo, hi;
  logic                  adj_done, adj_done_next, is_skp;
  logic [DATA_WIDTH-1:0] data_q, data_next;
  logic                  valid_q, valid_next;
  logic                  under_q, under_next;
  logic                  added_q, added_next;
  logic                  removed_q, removed_next;

  always_ff @(posedge read_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_N; i++) wsync[i] <= '0;
    end else begin
      wsync[0] <= bus.gray_write_pointer;
      for (int unsigned i = 1; i < SYNC_N; i++) wsync[i] <= wsync[i-1];
    end
  end

  grayToBin #(.WIDTH(PW)) u_gray_to_bin (.gray(wsync[SYNC_N-1]), .bin(wbin));
  // Gray is taken from rbin_next so the registered pointer always equals gray(rbin).
  binToGray #(.WIDTH(PW)) u_bin_to_gray (.bin(rbin_next), .gray(rgray_next));

  assign fill   = wbin - rbin;
  assign target = buffer_mode ? T_HALF : T_EMPTY;
  assign lo     = target - PW'(1);
  assign hi     = target + PW'(1);
  assign is_skp = (bus.data_in == DATA_WIDTH'(SKP_SYM_N)) ||
                  (bus.data_in == DATA_WIDTH'(SKP_SYM_P));

  always_comb begin
    state_next    = state;
    rbin_next     = rbin;
    adj_done_next = adj_done;
    data_next     = data_q;
    valid_next    = 1'b0;
    under_next    = 1'b0;
    added_next    = 1'b0;
    removed_next  = 1'b0;
    unique case (state)
      FILL: begin
        if (fill >= target) state_next = RUN;
      end
      RUN: begin
        if (fill == '0) begin
          under_next = 1'b1;
          state_next = FILL;
        end else if (is_skp && (fill <= lo) && !adj_done) begin
          // Hold the pointer so the same SKP is emitted again next cycle.
          data_next     = bus.data_in;
          valid_next    = 1'b1;
          added_next    = 1'b1;
          adj_done_next = 1'b1;
        end else if (is_skp && (fill >= hi) && !adj_done) begin
          rbin_next     = rbin + PW'(1);
          removed_next  = 1'b1;
          adj_done_next = 1'b1;
        end else begin
          rbin_next  = rbin + PW'(1);
          data_next  = bus.data_in;
          valid_next = 1'b1;
          if (!is_skp) adj_done_next = 1'b0;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge read_clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      rbin      <= '0;
      rgray     <= '0;
      adj_done  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      under_q   <= 1'b0;
      added_q   <= 1'b0;
      removed_q <= 1'b0;
    end else begin
      state     <= state_next;
      rbin      <= rbin_next;
      rgray     <= rgray_next;
      adj_done  <= adj_done_next;
      data_q    <= data_next;
      valid_q   <= valid_next;
      under_q   <= under_next;
      added_q   <= added_next;
      removed_q <= removed_next;
    end
  end

  assign bus.read_address      = rbin[ADDR_W-1:0];
  assign bus.gray_read_pointer = rgray;
  assign bus.data_out          = data_q;
  assign bus.data_valid        = valid_q;
  assign bus.underflow         = under_q;
  assign bus.skp_added         = added_q;
  assign bus.skp_removed       = removed_q;

endmodule

// File: tb/tb_read_pointer_control.sv
// Directed bench for read_pointer_control: models the write side (RAM + Gray
// write pointer) and checks outputs against hand-computed cycle expectations.
module tb_read_pointer_control;

  localparam int unsigned DW    = 10;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic buffer_mode;

  always #5 clk = ~clk;

  read_pointer_control_if #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) bus ();

  logic [DW-1:0] mem [DEPTH];
  logic [4:0]    wptr;

  assign bus.gray_write_pointer = wptr ^ (wptr >> 1);
  assign bus.data_in            = mem[bus.read_address];

  read_pointer_control #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) dut (
    .read_clk   (clk),
    .rst        (rst),
    .buffer_mode(buffer_mode),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_sym(input logic [DW-1:0] s);
    mem[wptr[3:0]] = s;
    wptr = wptr + 5'd1;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_dout"},  32'(bus.data_out), 0);
    check({pfx, "_valid"}, 32'(bus.data_valid), 0);
    check({pfx, "_addr"},  32'(bus.read_address), 0);
    check({pfx, "_gray"},  32'(bus.gray_read_pointer), 0);
    check({pfx, "_pulse"}, 32'({bus.underflow, bus.skp_added, bus.skp_removed}), 0);
  endtask

  // Reset released on a falling edge, so writes made right after land before edge E1.
  task automatic do_reset;
    @(negedge clk);
    rst  = 1'b1;
    wptr = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic scen1_and_underflow(input string pfx);
    do_reset;
    buffer_mode = 1'b0;
    write_sym(10'h111);
    repeat (4) tick;
    check({pfx, "_hold_valid"}, 32'(bus.data_valid), 0);
    check({pfx, "_hold_addr"},  32'(bus.read_address), 0);
    write_sym(10'h122);
    write_sym(10'h133);
    write_sym(10'h144);
    mem[4] = 10'h0F4;
    repeat (3) tick;
    check({pfx, "_enter_valid"}, 32'(bus.data_valid), 0);
    tick;
    check({pfx, "_d0"}, 32'({bus.data_valid, bus.data_out}), 32'h511);
    check({pfx, "_a0"}, 32'(bus.read_address), 1);
    tick;
    check({pfx, "_d1"}, 32'({bus.data_valid, bus.data_out}), 32'h522);
    tick;
    check({pfx, "_d2"}, 32'({bus.data_valid, bus.data_out}), 32'h533);
    tick;
    check({pfx, "_d3"}, 32'({bus.data_valid, bus.data_out}), 32'h544);
    check({pfx, "_a3"}, 32'(bus.read_address), 4);
    tick;
    check({pfx, "_uf"},       32'(bus.underflow), 1);
    check({pfx, "_uf_valid"}, 32'(bus.data_valid), 0);
    check({pfx, "_uf_noadd"}, 32'(bus.skp_added), 0);
    tick;
    check({pfx, "_uf_pulse"}, 32'(bus.underflow), 0);
    check({pfx, "_fill_valid"}, 32'(bus.data_valid), 0);
    check({pfx, "_fill_addr"},  32'(bus.read_address), 4);
  endtask

  int unsigned n, wrote, uf_seen, rm_seen;
  logic [4:0]  prev_g;
  logic [3:0]  prev_a;
  logic        seen_wrap;

  initial begin
    rst         = 1'b1;
    buffer_mode = 1'b0;
    wptr        = '0;
    #2;
    check_zero("rst");

    // Basic fill/run, in-order data, then underflow with a SKP at the head.
    scen1_and_underflow("s1");

    // SKP insertion at fill=1, second SKP of the run untouched.
    do_reset;
    buffer_mode = 1'b0;
    write_sym(10'h111);
    write_sym(10'h122);
    repeat (3) tick;
    write_sym(10'h0F4);
    tick;
    write_sym(10'h0F4);
    tick;
    check("s2_d122", 32'(bus.data_out), 32'h122);
    check("s2_noadd0", 32'(bus.skp_added), 0);
    tick;
    check("s2_add", 32'(bus.skp_added), 1);
    check("s2_dup1", 32'({bus.data_valid, bus.data_out}), 32'h4F4);
    check("s2_hold_addr", 32'(bus.read_address), 2);
    write_sym(10'h133);
    tick;
    check("s2_dup2", 32'({bus.data_valid, bus.data_out}), 32'h4F4);
    check("s2_add_pulse", 32'(bus.skp_added), 0);
    write_sym(10'h144);
    tick;
    check("s2_skp2", 32'({bus.data_valid, bus.data_out}), 32'h4F4);
    check("s2_no_readd", 32'(bus.skp_added), 0);
    check("s2_addr4", 32'(bus.read_address), 4);
    tick;
    check("s2_d133", 32'({bus.data_valid, bus.data_out}), 32'h533);

    // SKP deletion in half-full mode at fill=10.
    do_reset;
    buffer_mode = 1'b1;
    write_sym(10'h30B);
    for (int i = 1; i < 10; i++) write_sym(10'(10'h100 + i));
    repeat (3) tick;
    check("s3_enter_valid", 32'(bus.data_valid), 0);
    check("s3_enter_addr",  32'(bus.read_address), 0);
    tick;
    check("s3_removed", 32'(bus.skp_removed), 1);
    check("s3_del_valid", 32'(bus.data_valid), 0);
    check("s3_del_addr", 32'(bus.read_address), 1);
    tick;
    check("s3_next", 32'({bus.data_valid, bus.data_out}), 32'h501);
    check("s3_rm_pulse", 32'(bus.skp_removed), 0);
    check("s3_addr2", 32'(bus.read_address), 2);

    // 40-symbol stream across the read_address and pointer MSB wraps.
    do_reset;
    buffer_mode = 1'b0;
    write_sym(10'h200);
    wrote = 1; n = 0; uf_seen = 0; rm_seen = 0;
    prev_g = '0; prev_a = '0; seen_wrap = 1'b0;
    for (int c = 0; c < 80 && n < 40; c++) begin
      tick;
      if (bus.data_valid) begin
        check("s5_data", 32'(bus.data_out), 32'(10'h200 + n));
        n++;
      end
      check("s5_addr", 32'(bus.read_address), n % 16);
      check("s5_gray", 32'(bus.gray_read_pointer), 32'(5'(n) ^ (5'(n) >> 1)));
      check("s5_gstep", 32'($countones(bus.gray_read_pointer ^ prev_g)), 32'($countones(bus.gray_read_pointer ^ prev_g) <= 1 ? $countones(bus.gray_read_pointer ^ prev_g) : 1));
      if (prev_a == 4'd15 && bus.read_address == 4'd0) seen_wrap = 1'b1;
      if (bus.underflow) uf_seen++;
      if (bus.skp_removed || bus.skp_added) rm_seen++;
      prev_g = bus.gray_read_pointer;
      prev_a = bus.read_address;
      if (wrote < 40) begin
        write_sym(10'(10'h200 + wrote));
        wrote++;
      end
    end
    check("s5_count", n, 40);
    check("s5_wrap", 32'(seen_wrap), 1);
    check("s5_no_underflow", uf_seen, 0);
    check("s5_no_adjust", rm_seen, 0);

    // Asynchronous reset mid-stream, then recovery as in the first scenario.
    do_reset;
    buffer_mode = 1'b0;
    for (int i = 0; i < 4; i++) write_sym(10'(10'h111 * (i + 1)));
    repeat (5) tick;
    check("s6_pre", 32'({bus.data_valid, bus.data_out}), 32'h622);
    #2;
    rst = 1'b1;
    #1;
    check_zero("s6_async");
    scen1_and_underflow("s6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
